// File: rtl/reg_wb_ctrl.sv
// Register-file write-back controller: ALU results are queued in a FIFO and load results use a valid/ready handshake.
// Writes leave one cycle after the grant. A full FIFO wins arbitration and stalls loads, and further ALU pushes are dropped.
module reg_wb_ctrl #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        iss_en,
   input  logic [4:0]  iss_rd,
   input  logic        alu_valid,
   input  logic [4:0]  alu_rd,
   input  logic [31:0] alu_data,
   output logic        alu_ready,
   input  logic        mem_valid,
   input  logic [4:0]  mem_rd,
   input  logic [31:0] mem_data,
   output logic        mem_ready,
   output logic        wt_en,
   output logic [4:0]  wt_addr,
   output logic [31:0] wt_data,
   input  logic [4:0]  rs_a,
   input  logic [4:0]  rs_b,
   output logic        busy_a,
   output logic        busy_b,
   output logic        ovf
);

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } wb_ent_t;

   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = 1;
   localparam logic [AW-1:0] PTR_ONE  = 1;

   wb_ent_t       fifo_mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;
   logic          grant;
   wb_ent_t       grant_ent;
   logic [31:0]   sb;
   logic [31:0]   sb_nxt;

   assign full      = (count == FULL_CNT);
   assign empty     = (count == '0);
   assign alu_ready = !full;
   assign mem_ready = mem_valid && !full;
   assign push      = alu_valid && !full;
   // A full FIFO must drain even if a load is waiting, otherwise ALU results are lost.
   assign pop       = !empty && (full || !mem_valid);
   assign grant     = mem_ready || pop;

   always_comb begin
      grant_ent = fifo_mem[rd_ptr];
      if (mem_ready) begin
         grant_ent.rd   = mem_rd;
         grant_ent.data = mem_data;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= {alu_rd, alu_data};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         if (push && !pop)      count <= count + CNT_ONE;
         else if (pop && !push) count <= count - CNT_ONE;
         if (alu_valid && full) ovf <= 1'b1;
      end
   end

   // Entries targeting r0 are consumed but never written.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wt_en   <= 1'b0;
         wt_addr <= '0;
         wt_data <= '0;
      end else if (grant) begin
         wt_en   <= (grant_ent.rd != 5'd0);
         wt_addr <= grant_ent.rd;
         wt_data <= grant_ent.data;
      end else begin
         wt_en   <= 1'b0;
      end
   end

   // Set after clear so a same-edge issue to the retiring register stays busy.
   always_comb begin
      sb_nxt = sb;
      if (wt_en)  sb_nxt[wt_addr] = 1'b0;
      if (iss_en) sb_nxt[iss_rd]  = 1'b1;
      sb_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sb <= '0;
      else     sb <= sb_nxt;
   end

   assign busy_a = (rs_a != 5'd0) && sb[rs_a];
   assign busy_b = (rs_b != 5'd0) && sb[rs_b];

endmodule

// File: tb/tb_reg_wb_ctrl.sv
// Directed bench for reg_wb_ctrl: ALU path, load priority, full FIFO, r0 handling, scoreboard collision, reset.
module tb_reg_wb_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        iss_en;
   logic [4:0]  iss_rd;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        alu_ready;
   logic        mem_valid;
   logic [4:0]  mem_rd;
   logic [31:0] mem_data;
   logic        mem_ready;
   logic        wt_en;
   logic [4:0]  wt_addr;
   logic [31:0] wt_data;
   logic [4:0]  rs_a;
   logic [4:0]  rs_b;
   logic        busy_a;
   logic        busy_b;
   logic        ovf;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   reg_wb_ctrl #(.DEPTH(4), .AW(2)) dut (
      .clk(clk), .rst(rst),
      .iss_en(iss_en), .iss_rd(iss_rd),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
      .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
      .wt_en(wt_en), .wt_addr(wt_addr), .wt_data(wt_data),
      .rs_a(rs_a), .rs_b(rs_b), .busy_a(busy_a), .busy_b(busy_b),
      .ovf(ovf)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
      end
   endtask

   task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_wr(input string tag, input logic [4:0] addr, input logic [31:0] data);
      chk1({tag, "_en"}, wt_en, 1'b1);
      chkw({tag, "_addr"}, {27'd0, wt_addr}, {27'd0, addr});
      chkw({tag, "_data"}, wt_data, data);
   endtask

   initial begin
      rst = 1'b1; iss_en = 1'b0; iss_rd = '0;
      alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
      mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
      rs_a = '0; rs_b = '0;
      tick(); tick();
      chk1("rst_wt_en", wt_en, 1'b0);
      chk1("rst_alu_ready", alu_ready, 1'b1);
      chk1("rst_mem_ready", mem_ready, 1'b0);
      chk1("rst_ovf", ovf, 1'b0);
      rst = 1'b0;

      // Single ALU result with scoreboard tracking
      iss_en = 1'b1; iss_rd = 5'd5; rs_a = 5'd5;
      tick();
      iss_en = 1'b0; alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
      #1 chk1("alu_busy_issued", busy_a, 1'b1);
      tick();
      alu_valid = 1'b0;
      #1 chk1("alu_busy_queued", busy_a, 1'b1);
      chk1("alu_no_write_yet", wt_en, 1'b0);
      tick();
      chk_wr("alu_wr", 5'd5, 32'hDEADBEEF);
      chk1("alu_busy_at_write", busy_a, 1'b1);
      tick();
      chk1("alu_busy_cleared", busy_a, 1'b0);
      chk1("alu_wt_idle", wt_en, 1'b0);
      chkw("alu_addr_hold", {27'd0, wt_addr}, 32'd5);

      // Load priority over queued ALU results
      alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'h0000000A;
      #1 chk1("ld_no_mem_ready", mem_ready, 1'b0);
      tick();
      alu_rd = 5'd11; alu_data = 32'h0000000B;
      mem_valid = 1'b1; mem_rd = 5'd12; mem_data = 32'h0C0C0C0C;
      #1 chk1("ld_ready_first", mem_ready, 1'b1);
      tick();
      chk_wr("ld_wr_first", 5'd12, 32'h0C0C0C0C);
      alu_valid = 1'b0; mem_rd = 5'd7; mem_data = 32'h12345678;
      #1 chk1("ld_ready_fifo2", mem_ready, 1'b1);
      tick();
      chk_wr("ld_wr_load", 5'd7, 32'h12345678);
      mem_valid = 1'b0;
      tick();
      chk_wr("ld_wr_fifo0", 5'd10, 32'h0000000A);
      tick();
      chk_wr("ld_wr_fifo1", 5'd11, 32'h0000000B);
      tick();
      chk1("ld_drained", wt_en, 1'b0);

      // Full FIFO with loads pending, then overflow
      mem_valid = 1'b1; mem_rd = 5'd20; mem_data = 32'h00000020;
      alu_valid = 1'b1; alu_rd = 5'd21; alu_data = 32'h00000021;
      #1 chk1("full_mem_ready_p1", mem_ready, 1'b1);
      tick();
      alu_rd = 5'd22; alu_data = 32'h00000022;
      tick();
      alu_rd = 5'd23; alu_data = 32'h00000023;
      tick();
      alu_rd = 5'd24; alu_data = 32'h00000024;
      #1 chk1("full_alu_ready_cnt3", alu_ready, 1'b1);
      tick();
      alu_rd = 5'd25; alu_data = 32'h00000025;
      #1 chk1("full_alu_ready", alu_ready, 1'b0);
      chk1("full_mem_ready", mem_ready, 1'b0);
      chk1("full_ovf_before", ovf, 1'b0);
      chk_wr("full_wr_load", 5'd20, 32'h00000020);
      tick();
      alu_valid = 1'b0;
      #1 chk1("full_ovf_set", ovf, 1'b1);
      chk1("full_mem_ready_back", mem_ready, 1'b1);
      chk1("full_alu_ready_back", alu_ready, 1'b1);
      chk_wr("full_wr_head", 5'd21, 32'h00000021);
      tick();
      mem_valid = 1'b0;
      chk_wr("full_wr_load2", 5'd20, 32'h00000020);
      tick();
      chk_wr("full_wr_22", 5'd22, 32'h00000022);
      tick();
      chk_wr("full_wr_23", 5'd23, 32'h00000023);
      tick();
      chk_wr("full_wr_24", 5'd24, 32'h00000024);
      tick();
      chk1("full_no_dropped_write", wt_en, 1'b0);
      chk1("full_ovf_sticky", ovf, 1'b1);

      // Register 0: consumed without a write, never busy
      iss_en = 1'b1; iss_rd = 5'd0; rs_a = 5'd0;
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFFFFFF;
      tick();
      iss_en = 1'b0; alu_valid = 1'b0;
      #1 chk1("r0_not_busy", busy_a, 1'b0);
      tick();
      chk1("r0_no_write", wt_en, 1'b0);
      alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h00000044;
      tick();
      alu_valid = 1'b0;
      chk1("r0_no_write2", wt_en, 1'b0);
      tick();
      chk_wr("r0_next_entry", 5'd4, 32'h00000044);
      tick();

      // Same-edge set and clear on register 9
      iss_en = 1'b1; iss_rd = 5'd9; rs_b = 5'd9;
      tick();
      iss_en = 1'b0; alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h00000099;
      tick();
      alu_valid = 1'b0;
      tick();
      chk_wr("col_wr", 5'd9, 32'h00000099);
      iss_en = 1'b1; iss_rd = 5'd9;
      tick();
      iss_en = 1'b0;
      #1 chk1("col_busy_set_wins", busy_b, 1'b1);
      tick();
      chk1("col_busy_held", busy_b, 1'b1);

      // Reset mid-stream with three queued ALU results
      iss_en = 1'b1; iss_rd = 5'd3; rs_a = 5'd3;
      mem_valid = 1'b1; mem_rd = 5'd14; mem_data = 32'h00000014;
      alu_valid = 1'b1; alu_rd = 5'd13; alu_data = 32'h00000013;
      tick();
      iss_en = 1'b0; alu_rd = 5'd15; alu_data = 32'h00000015;
      tick();
      alu_rd = 5'd16; alu_data = 32'h00000016;
      tick();
      alu_valid = 1'b0; mem_valid = 1'b0;
      #1 chk1("pre_rst_busy3", busy_a, 1'b1);
      chk1("pre_rst_wt_en", wt_en, 1'b1);
      chk1("pre_rst_ovf", ovf, 1'b1);
      rst = 1'b1;
      #1 chk1("mid_rst_wt_en", wt_en, 1'b0);
      chk1("mid_rst_alu_ready", alu_ready, 1'b1);
      chk1("mid_rst_ovf", ovf, 1'b0);
      chk1("mid_rst_busy_b9", busy_b, 1'b0);
      for (int i = 0; i < 32; i++) begin
         rs_a = 5'(i);
         #1 chk1($sformatf("mid_rst_busy_a%0d", i), busy_a, 1'b0);
      end
      tick();
      rst = 1'b0;
      tick();
      tick();
      chk1("post_rst_discard1", wt_en, 1'b0);
      tick();
      chk1("post_rst_discard2", wt_en, 1'b0);
      chk1("post_rst_ovf", ovf, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/reg_wb_ctrl.md
Name: reg_wb_ctrl

Overview:
- Write-side controller for the 32x32 register file. It collects completed results from two producers: the ALU, which has no backpressure and is buffered in a FIFO, and the load unit, which uses a valid/ready handshake.
- It serialises those results onto the register file's single write port (Wt_addr/Wt_data/L_S).
- It keeps a pending-write scoreboard so the decode stage can detect RAW hazards on its two read addresses.

Parameters:
- DEPTH, 4, number of ALU result FIFO entries; must be a power of 2, minimum 2.
- AW, 2, FIFO pointer width; equals log2(DEPTH).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- iss_en  input  1  an instruction with a destination register issues this cycle.
- iss_rd  input  5  destination register of the issuing instruction.
- alu_valid  input  1  ALU result available this cycle.
- alu_rd  input  5  ALU result destination.
- alu_data  input  32  ALU result value.
- alu_ready  output  1  FIFO can accept an entry; equals (count != DEPTH).
- mem_valid  input  1  load result available; held stable until accepted.
- mem_rd  input  5  load destination.
- mem_data  input  32  load value.
- mem_ready  output  1  load result accepted this cycle (combinational).
- wt_en  output  1  register file write enable; drives L_S.
- wt_addr  output  5  register file write address.
- wt_data  output  32  register file write data.
- rs_a  input  5  decode read address A.
- rs_b  input  5  decode read address B.
- busy_a  output  1  rs_a has an outstanding write (combinational).
- busy_b  output  1  rs_b has an outstanding write (combinational).
- ovf  output  1  sticky flag: an ALU push arrived while the FIFO was full.

Behaviour:
- Reset (asynchronous):
  - FIFO pointers and count go to 0.
  - Scoreboard goes to all 0.
  - wt_en, wt_addr, wt_data and ovf go to 0.
  - Reset mid-operation discards all queued and pending results.
- FIFO push: occurs when alu_valid=1 and count!=DEPTH; stores {alu_rd, alu_data}.
- FIFO overflow: alu_valid=1 while count==DEPTH drops the result and sets ovf. ovf clears only on rst.
- Arbitration, once per cycle, one grant at most:
  - count==DEPTH: the FIFO head wins and mem_ready=0.
  - Otherwise, mem_valid=1: the load wins and mem_ready=1.
  - Otherwise, count!=0: the FIFO head wins.
  - Otherwise: no grant.
- FIFO push and pop may occur in the same cycle; count is then unchanged. A push into an empty FIFO is not poppable until the next cycle, so there is no bypass.
- Write port (registered, 1-cycle latency):
  - On the edge after a grant: wt_en<=1, wt_addr<=granted rd, wt_data<=granted data.
  - With no grant: wt_en<=0, and wt_addr/wt_data hold their values.
  - A granted entry with rd==0 is consumed (popped or handshaken) but produces wt_en<=0.
- Scoreboard (31 bits, index 1..31):
  - Set on an edge where iss_en=1 and iss_rd!=0.
  - Cleared on an edge where wt_en=1, at bit wt_addr. This is the same edge on which the register file stores the data.
  - If set and clear hit the same register on the same edge, set wins.
  - Register 0 is never busy.
- busy_a = scoreboard[rs_a] when rs_a!=0, else 0; busy_b is the same for rs_b.
- Ordering: results leave in FIFO order. A load may overtake queued ALU results. The pipeline guarantees no two in-flight writes target the same rd.

Test Plan:
- Reset check: assert rst mid-stream with FIFO count=3 -> wt_en=0, alu_ready=1, busy_a=0 for all rs_a, ovf=0 immediately, without waiting for a clock edge.
- Single ALU path: iss_en, iss_rd=5; next cycle alu_valid, rd=5, data=0xDEADBEEF -> wt_en=1, wt_addr=5, wt_data=0xDEADBEEF two edges after push. busy_a(rs_a=5) stays 1 until that wt_en edge, then reads 0.
- Load priority: FIFO holds 2 entries and mem_valid=1 (rd=7, data=0x12345678) -> mem_ready=1 that cycle. The load is written first, then the FIFO entries follow in push order.
- Full FIFO: 4 ALU pushes with mem_valid held high -> count reaches 4, mem_ready=0, alu_ready=0. A 5th push sets ovf=1 and is never written. After one drain, mem_ready returns to 1.
- Zero register: alu push rd=0, data=0xFFFFFFFF -> entry consumed and wt_en stays 0. iss_rd=0 leaves busy=0.
- Set/clear collision: wt_en=1, wt_addr=9 on the same edge as iss_en=1, iss_rd=9 -> busy for register 9 reads 1 after that edge.
